mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH_IN, default 8, operand width.
REQ-003 SHALL have parameter WIDTH_OUT, default 16, product width.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RST_N  input  1  synchronous active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester request strobe.
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot accept, at most one bit high.
REQ-008 SHALL have port req_a  input  NUM_REQ*WIDTH_IN  packed operand A, requester i at [i*WIDTH_IN +: WIDTH_IN].
REQ-009 SHALL have port req_b  input  NUM_REQ*WIDTH_IN  packed operand B, same packing as req_a.
REQ-010 SHALL have port rsp_valid  output  1  result available.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-012 SHALL have port rsp_id  output  clog2(NUM_REQ)  index of the requester that owns the result.
REQ-013 SHALL have port rsp_product  output  WIDTH_OUT  A*B.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE, one shared repeated-add datapath.
REQ-016 IDLE: if any req_valid, SHALL grant round-robin, searching from last_grant+1 with wrap; req_ready[g] high combinationally in that cycle only.
REQ-017 Accept edge (IDLE, req_valid[g]): SHALL latch count=min(a,b), addend=max(a,b), sum=0, id=g; go to RUN.
REQ-018 RUN, count!=0: SHALL do sum<=sum+addend and count<=count-1 each cycle.
REQ-019 RUN, count==0: SHALL load rsp_product<=sum and rsp_id<=id, go to DONE.
REQ-020 Latency SHALL be min(a,b)+1 edges from the accept edge to rsp_valid high; operand zero gives 1 edge.
REQ-021 DONE: rsp_valid=1; rsp_id and rsp_product SHALL hold stable until rsp_valid&&rsp_ready.
REQ-022 DONE handshake edge SHALL update last_grant<=id and return to IDLE; no new grant in that same cycle.
REQ-023 req_ready SHALL be all-zero in RUN and DONE; new or withdrawn req_valid there SHALL have no effect.
REQ-024 Sum without overflow option SHALL wrap modulo 2^WIDTH_OUT.

Reset
REQ-025 RST_N low at an edge SHALL force IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), rsp_valid=0, rsp_product=0, rsp_id=0, busy=0, req_ready=0.
REQ-026 Reset in RUN or DONE SHALL abort the operation silently; no response is ever issued for it.

Configuration
REQ-027 Macro MULT_ARB_OVF_EN defined: SHALL add output rsp_ovf (1 bit); accumulator tracks a sticky carry; on overflow rsp_product=all-ones and rsp_ovf=1, valid with rsp_valid, reset 0.
REQ-028 Macro MULT_ARB_OVF_EN undefined: SHALL have no rsp_ovf port and wrap per REQ-024.

Structure
REQ-029 Package mult_arb_pkg SHALL hold the FSM state encoding (IDLE=0, RUN=1, DONE=2) and the default width constants.
REQ-030 Round-robin selection SHALL be sub-module mult_arb_rr: inputs req_valid and last_grant, outputs one-hot grant and index, purely combinational.

Verification
REQ-031 After reset, req0 only, a=3 b=5 -> accept, rsp_valid 4 edges later, rsp_product=15, rsp_id=0.
REQ-032 All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0, with one idle cycle between grants.
REQ-033 req2 a=0 b=200 -> rsp_valid 1 edge after accept, rsp_product=0, rsp_id=2; a=255 b=255 -> 65025 after 256 edges.
REQ-034 rsp_ready low 10 cycles in DONE with req1 valid -> rsp outputs stable, req_ready stays 0, req1 accepted only after the handshake.
REQ-035 RST_N low mid-RUN (a=10 b=10, after 4 edges) -> next cycle all outputs at reset values, no response for the aborted request.
REQ-036 WIDTH_OUT=12, a=b=255 -> with MULT_ARB_OVF_EN: product 0xFFF and rsp_ovf=1; without it: product 0xE01.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier arbiter: FSM encoding and default widths.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_WIDTH_IN  = 8;
    localparam int DEF_WIDTH_OUT = 16;

endpackage

// File: rtl/mult_arb_rr.sv
// Combinational round-robin picker: searches from last_grant+1 upward with wrap.
module mult_arb_rr #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        // Walk offsets from farthest to nearest so the nearest valid requester wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            logic [IDW-1:0] idx;
            idx = IDW'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter in front of one shared repeated-add multiplier.
// Optional saturating overflow flag enabled with macro MULT_ARB_OVF_EN.
//
// state | meaning
// IDLE  | waiting for a request; grants one requester combinationally
// RUN   | adding max(a,b) into the sum min(a,b) times
// DONE  | result presented, held until rsp_ready
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int WIDTH_IN  = DEF_WIDTH_IN,
    parameter int WIDTH_OUT = DEF_WIDTH_OUT
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH_IN-1:0]  req_a,
    input  logic [NUM_REQ*WIDTH_IN-1:0]  req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [WIDTH_OUT-1:0]         rsp_product,
`ifdef MULT_ARB_OVF_EN
    output logic                         rsp_ovf,
`endif
    output logic                         busy
);

    localparam int IDW = $clog2(NUM_REQ);

    state_t               state;
    logic [IDW-1:0]       last_grant;
    logic [IDW-1:0]       cur_id;
    logic [WIDTH_IN-1:0]  count;
    logic [WIDTH_IN-1:0]  addend;
    logic [WIDTH_OUT-1:0] sum;
    logic [WIDTH_OUT-1:0] addend_ext;
    logic [WIDTH_OUT-1:0] sum_next;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       grant_idx;
    logic [WIDTH_IN-1:0]  sel_a;
    logic [WIDTH_IN-1:0]  sel_b;

    mult_arb_rr #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a = req_a[i*WIDTH_IN +: WIDTH_IN];
                sel_b = req_b[i*WIDTH_IN +: WIDTH_IN];
            end
        end
    end

    // Gated by RST_N so nothing looks accepted while reset is being applied.
    assign req_ready  = (state == ST_IDLE && RST_N) ? grant : '0;
    assign addend_ext = WIDTH_OUT'(addend);

`ifdef MULT_ARB_OVF_EN
    logic [WIDTH_OUT:0] sum_ext;
    logic               ovf_acc;
    assign sum_ext  = {1'b0, sum} + {1'b0, addend_ext};
    assign sum_next = sum_ext[WIDTH_OUT-1:0];
`else
    assign sum_next = sum + addend_ext;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            last_grant  <= IDW'(NUM_REQ - 1);
            cur_id      <= '0;
            count       <= '0;
            addend      <= '0;
            sum         <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
            busy        <= 1'b0;
`ifdef MULT_ARB_OVF_EN
            ovf_acc     <= 1'b0;
            rsp_ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        count  <= (sel_a < sel_b) ? sel_a : sel_b;
                        addend <= (sel_a < sel_b) ? sel_b : sel_a;
                        sum    <= '0;
                        cur_id <= grant_idx;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
`ifdef MULT_ARB_OVF_EN
                        ovf_acc <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    if (count != '0) begin
                        sum   <= sum_next;
                        count <= count - 1'b1;
`ifdef MULT_ARB_OVF_EN
                        ovf_acc <= ovf_acc | sum_ext[WIDTH_OUT];
`endif
                    end else begin
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= ST_DONE;
`ifdef MULT_ARB_OVF_EN
                        rsp_product <= ovf_acc ? '1 : sum;
                        rsp_ovf     <= ovf_acc;
`else
                        rsp_product <= sum;
`endif
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= cur_id;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: vector table plus hand-written corner sequences.
module tb_mult_arbiter;

    localparam int NR  = 4;
    localparam int WI  = 8;
    localparam int WO  = 16;
    localparam int IDW = 2;

    logic              CLK;
    logic              RST_N;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*WI-1:0]  req_a;
    logic [NR*WI-1:0]  req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [WO-1:0]     rsp_product;
    logic              busy;

    logic [NR-1:0]     r12_valid;
    logic [NR-1:0]     r12_ready;
    logic [NR*WI-1:0]  r12_a;
    logic [NR*WI-1:0]  r12_b;
    logic              r12_rsp_valid;
    logic              r12_rsp_ready;
    logic [IDW-1:0]    r12_rsp_id;
    logic [11:0]       r12_product;
    logic              r12_busy;
`ifdef MULT_ARB_OVF_EN
    logic              rsp_ovf;
    logic              r12_ovf;
`endif

    mult_arbiter #(.NUM_REQ(NR), .WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
`ifdef MULT_ARB_OVF_EN
        .rsp_ovf     (rsp_ovf),
`endif
        .busy        (busy)
    );

    mult_arbiter #(.NUM_REQ(NR), .WIDTH_IN(WI), .WIDTH_OUT(12)) dut12 (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .req_valid   (r12_valid),
        .req_ready   (r12_ready),
        .req_a       (r12_a),
        .req_b       (r12_b),
        .rsp_valid   (r12_rsp_valid),
        .rsp_ready   (r12_rsp_ready),
        .rsp_id      (r12_rsp_id),
        .rsp_product (r12_product),
`ifdef MULT_ARB_OVF_EN
        .rsp_ovf     (r12_ovf),
`endif
        .busy        (r12_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int id;
        int a;
        int b;
        int prod;
        int lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        step();
        step();
        RST_N = 1'b1;
    endtask

    task automatic set_req(input int id, input int a, input int b);
        logic [31:0] av;
        logic [31:0] bv;
        av = a;
        bv = b;
        req_valid[id]       = 1'b1;
        req_a[id*WI +: WI]  = av[WI-1:0];
        req_b[id*WI +: WI]  = bv[WI-1:0];
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 600) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;
        int ng;
        int cyc;
        logic [NR-1:0] gr[5];
        int gc[5];
        logic [31:0] onehot;

        vecs[0] = '{id: 0, a: 3,   b: 5,   prod: 15,    lat: 4};
        vecs[1] = '{id: 2, a: 0,   b: 200, prod: 0,     lat: 1};
        vecs[2] = '{id: 1, a: 7,   b: 9,   prod: 63,    lat: 8};
        vecs[3] = '{id: 3, a: 255, b: 255, prod: 65025, lat: 256};
        vecs[4] = '{id: 1, a: 200, b: 0,   prod: 0,     lat: 1};
        vecs[5] = '{id: 3, a: 12,  b: 1,   prod: 12,    lat: 2};
        vecs[6] = '{id: 0, a: 1,   b: 1,   prod: 1,     lat: 2};

        RST_N         = 1'b0;
        req_valid     = '0;
        req_a         = '0;
        req_b         = '0;
        rsp_ready     = 1'b0;
        r12_valid     = '0;
        r12_a         = '0;
        r12_b         = '0;
        r12_rsp_ready = 1'b0;
        do_reset();

        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_product", 32'(rsp_product), 0);
        chk("reset_id", 32'(rsp_id), 0);

        for (int i = 0; i < 7; i++) begin
            req_valid = '0;
            set_req(vecs[i].id, vecs[i].a, vecs[i].b);
            #1;
            onehot = 32'd1 << vecs[i].id;
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), onehot);
            step();
            req_valid = '0;
            wait_rsp(lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_product", i), 32'(rsp_product), vecs[i].prod);
            chk($sformatf("v%0d_id", i), 32'(rsp_id), vecs[i].id);
            chk($sformatf("v%0d_busy", i), 32'(busy), 1);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            chk($sformatf("v%0d_rsp_drop", i), 32'(rsp_valid), 0);
        end

        // Reset in the middle of a 10x10 operation.
        set_req(0, 10, 10);
        #1;
        step();
        req_valid = '0;
        repeat (4) step();
        chk("abort_busy_before", 32'(busy), 1);
        RST_N     = 1'b0;
        req_valid = '1;
        #1;
        chk("abort_ready_in_reset", 32'(req_ready), 0);
        step();
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_product", 32'(rsp_product), 0);
        chk("abort_id", 32'(rsp_id), 0);
        chk("abort_req_ready", 32'(req_ready), 0);
        req_valid = '0;
        RST_N     = 1'b1;
        seen = 0;
        repeat (20) begin
            step();
            if (rsp_valid) seen++;
        end
        chk("abort_no_response", seen, 0);

        // All requesters valid, consumer always ready: fair rotation.
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1, 1);
        rsp_ready = 1'b1;
        #1;
        ng  = 0;
        cyc = 0;
        while (ng < 5 && cyc < 200) begin
            if (req_ready != '0) begin
                gr[ng] = req_ready;
                gc[ng] = cyc;
                ng++;
            end
            step();
            cyc++;
        end
        chk("rr_grant_count", ng, 5);
        for (int k = 0; k < ng; k++) begin
            onehot = 32'd1 << (k % NR);
            chk($sformatf("rr_grant%0d", k), 32'(gr[k]), onehot);
            if (k > 0) chk($sformatf("rr_spacing%0d", k), gc[k] - gc[k-1], 4);
        end
        req_valid = '0;
        rsp_ready = 1'b0;

        // Consumer stalls in DONE while another requester waits.
        do_reset();
        set_req(0, 2, 3);
        #1;
        step();
        req_valid = '0;
        set_req(1, 4, 5);
        wait_rsp(lat);
        chk("stall_latency", lat, 3);
        chk("stall_product", 32'(rsp_product), 6);
        chk("stall_id", 32'(rsp_id), 0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (!rsp_valid || rsp_product !== 16'd6 || rsp_id !== 2'd0 || req_ready !== '0) seen++;
        end
        chk("stall_hold_errors", seen, 0);
        rsp_ready = 1'b1;
        #1;
        chk("stall_ready_at_handshake", 32'(req_ready), 0);
        step();
        rsp_ready = 1'b0;
        chk("stall_grant_after", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        wait_rsp(lat);
        chk("stall_req1_product", 32'(rsp_product), 20);
        chk("stall_req1_id", 32'(rsp_id), 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Narrow product: 255*255 does not fit in 12 bits.
        do_reset();
        r12_valid[0]  = 1'b1;
        r12_a[7:0]    = 8'd255;
        r12_b[7:0]    = 8'd255;
        #1;
        chk("w12_req_ready", 32'(r12_ready), 1);
        step();
        r12_valid = '0;
        lat = 0;
        while (!r12_rsp_valid && lat < 600) begin
            step();
            lat++;
        end
        chk("w12_latency", lat, 256);
`ifdef MULT_ARB_OVF_EN
        chk("w12_product", 32'(r12_product), 32'hFFF);
        chk("w12_ovf", 32'(r12_ovf), 1);
`else
        chk("w12_product", 32'(r12_product), 32'hE01);
`endif
        r12_rsp_ready = 1'b1;
        step();
        r12_rsp_ready = 1'b0;
        chk("w12_rsp_drop", 32'(r12_rsp_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
